// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode-side handshake and EX-side operand bus of the ID/EX stage
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [REG_ADDR_W-1:0]    id_rs1;
    logic [REG_ADDR_W-1:0]    id_rs2;
    logic [REG_ADDR_W-1:0]    id_rd;
    logic [DATA_WIDTH-1:0]    id_rs1_data;
    logic [DATA_WIDTH-1:0]    id_rs2_data;
    logic [DATA_WIDTH-1:0]    id_imm;
    logic [DATA_WIDTH-1:0]    id_pc;
    logic [OPCODE_LENGTH-1:0] id_alu_op;
    logic [1:0]               id_a_sel;
    logic                     id_b_imm;
    logic                     id_reg_write;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    store_data;
    logic [REG_ADDR_W-1:0]    ex_rd;
    logic                     ex_reg_write;
    logic                     load_use_stall;

    modport slave (
        input  in_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_alu_op, id_a_sel, id_b_imm, id_reg_write, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, store_data, ex_rd, ex_reg_write,
               load_use_stall
    );

    modport master (
        output in_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_alu_op, id_a_sel, id_b_imm, id_reg_write, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, store_data, ex_rd, ex_reg_write,
               load_use_stall
    );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with EX/MEM and MEM/WB operand bypass and load-use hold
module alu_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic                  exm_we,
    input  logic                  exm_is_load,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_we,
    input  logic [DATA_WIDTH-1:0] wb_result,
    alu_operand_stage_if.slave    bus
);
    logic                     valid_q;
    logic [REG_ADDR_W-1:0]    rs1_q;
    logic [REG_ADDR_W-1:0]    rs2_q;
    logic [REG_ADDR_W-1:0]    rd_q;
    logic [DATA_WIDTH-1:0]    rs1_data_q;
    logic [DATA_WIDTH-1:0]    rs2_data_q;
    logic [DATA_WIDTH-1:0]    imm_q;
    logic [DATA_WIDTH-1:0]    pc_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic [1:0]               a_sel_q;
    logic                     b_imm_q;
    logic                     reg_write_q;
    logic [DATA_WIDTH-1:0]    fwd1;
    logic [DATA_WIDTH-1:0]    fwd2;
    logic                     stall;
    logic                     out_valid;
    logic                     out_fire;
    logic                     in_ready;
    logic                     in_fire;

    // a loaded value is still in flight at EX/MEM, so only its MEM/WB copy may be bypassed
    function automatic logic [DATA_WIDTH-1:0] forward(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [DATA_WIDTH-1:0] held
    );
        return (rs == '0) ? '0 :
               (exm_we && exm_rd == rs && !exm_is_load) ? exm_result :
               (wb_we && wb_rd == rs) ? wb_result : held;
    endfunction

    always_comb begin
        fwd1      = forward(rs1_q, rs1_data_q);
        fwd2      = forward(rs2_q, rs2_data_q);
        stall     = valid_q && exm_is_load && exm_we && exm_rd != '0 &&
                    ((a_sel_q[0] == a_sel_q[1] && exm_rd == rs1_q) || exm_rd == rs2_q);
        out_valid = valid_q && !stall;
        out_fire  = out_valid && bus.out_ready;
        in_ready  = !valid_q || out_fire;
        in_fire   = bus.in_valid && in_ready;
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.load_use_stall = stall;
    assign bus.Operation      = out_valid ? op_q : '1;
    assign bus.SrcA           = !out_valid ? '0 : a_sel_q == 2'b01 ? pc_q : a_sel_q == 2'b10 ? '0 : fwd1;
    assign bus.SrcB           = !out_valid ? '0 : b_imm_q ? imm_q : fwd2;
    assign bus.store_data     = out_valid ? fwd2 : '0;
    assign bus.ex_rd          = rd_q;
    assign bus.ex_reg_write   = out_valid && reg_write_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            op_q        <= '0;
            a_sel_q     <= '0;
            b_imm_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_fire) begin
            valid_q     <= 1'b1;
            rs1_q       <= bus.id_rs1;
            rs2_q       <= bus.id_rs2;
            rd_q        <= bus.id_rd;
            rs1_data_q  <= bus.id_rs1_data;
            rs2_data_q  <= bus.id_rs2_data;
            imm_q       <= bus.id_imm;
            pc_q        <= bus.id_pc;
            op_q        <= bus.id_alu_op;
            a_sel_q     <= bus.id_a_sel;
            b_imm_q     <= bus.id_b_imm;
            reg_write_q <= bus.id_reg_write;
        end else if (out_fire) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            rs1_data_q <= fwd1;
            rs2_data_q <= fwd2;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed checks of issue, bypass, load-use hold, backpressure, flush and reset
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  exm_rd = '0;
    logic        exm_we = 1'b0;
    logic        exm_is_load = 1'b0;
    logic [31:0] exm_result = '0;
    logic [4:0]  wb_rd = '0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_result = '0;
    int          checks = 0;
    int          failures = 0;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .exm_rd(exm_rd), .exm_we(exm_we), .exm_is_load(exm_is_load), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [3:0] op, input logic [1:0] a_sel, input logic b_imm,
                         input logic [4:0] rd);
        bus.in_valid     = 1'b1;
        bus.id_rs1       = rs1;
        bus.id_rs1_data  = d1;
        bus.id_rs2       = rs2;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_pc        = pc;
        bus.id_alu_op    = op;
        bus.id_a_sel     = a_sel;
        bus.id_b_imm     = b_imm;
        bus.id_rd        = rd;
        bus.id_reg_write = 1'b1;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_operation", bus.Operation, 4'hF);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_srca", bus.SrcA, 0);
        chk("rst_ex_reg_write", bus.ex_reg_write, 0);

        // plain ADD then a back-to-back immediate op
        bus.out_ready = 1'b1;
        instr(1, 5, 2, 7, 0, 0, 4'h3, 2'b00, 1'b0, 5'd5);
        step();
        chk("add_valid", bus.out_valid, 1);
        chk("add_srca", bus.SrcA, 5);
        chk("add_srcb", bus.SrcB, 7);
        chk("add_op", bus.Operation, 4'h3);
        chk("add_rd", bus.ex_rd, 5);
        chk("add_rw", bus.ex_reg_write, 1);
        chk("add_in_ready", bus.in_ready, 1);
        instr(1, 9, 2, 11, 32'h100, 0, 4'h4, 2'b11, 1'b1, 5'd6);
        step();
        chk("b2b_srca", bus.SrcA, 9);
        chk("b2b_srcb", bus.SrcB, 32'h100);
        chk("b2b_op", bus.Operation, 4'h4);
        chk("b2b_store", bus.store_data, 11);

        // bypass priority and x0 handling, all within one held cycle
        instr(3, 32'h77, 0, 32'h99, 0, 0, 4'h0, 2'b00, 1'b1, 5'd7);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        exm_we = 1'b1; exm_rd = 0; exm_result = 32'h10;
        wb_we = 1'b1; wb_rd = 0; wb_result = 32'h20;
        #1;
        chk("fwd_rd0_srca", bus.SrcA, 32'h77);
        chk("x0_store", bus.store_data, 0);
        exm_rd = 3; wb_rd = 3;
        #1;
        chk("fwd_exm_prio", bus.SrcA, 32'h10);
        exm_we = 1'b0;
        #1;
        chk("fwd_wb", bus.SrcA, 32'h20);
        chk("hold_in_ready", bus.in_ready, 0);
        wb_we = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_op", bus.Operation, 4'hF);

        // load-use on rs1
        exm_is_load = 1'b1; exm_we = 1'b1; exm_rd = 4; exm_result = 32'hDEAD;
        instr(4, 32'h11, 0, 0, 0, 0, 4'h2, 2'b00, 1'b1, 5'd8);
        step();
        bus.in_valid = 1'b0;
        chk("lu_stall", bus.load_use_stall, 1);
        chk("lu_valid", bus.out_valid, 0);
        chk("lu_in_ready", bus.in_ready, 0);
        chk("lu_op", bus.Operation, 4'hF);
        step();
        exm_is_load = 1'b0; exm_we = 1'b0;
        wb_we = 1'b1; wb_rd = 4; wb_result = 32'hAB;
        #1;
        chk("lu_release_stall", bus.load_use_stall, 0);
        chk("lu_release_valid", bus.out_valid, 1);
        chk("lu_release_srca", bus.SrcA, 32'hAB);
        step();
        wb_we = 1'b0;
        chk("lu_done_valid", bus.out_valid, 0);

        // backpressure with one-cycle wb bypass to rs2 that must be retained
        instr(0, 0, 6, 32'h33, 0, 0, 4'h5, 2'b10, 1'b0, 5'd9);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        wb_we = 1'b1; wb_rd = 6; wb_result = 32'h55;
        #1;
        chk("bp1_in_ready", bus.in_ready, 0);
        step();
        wb_we = 1'b0;
        chk("bp2_in_ready", bus.in_ready, 0);
        chk("bp2_srcb", bus.SrcB, 32'h55);
        chk("bp2_srca_zero", bus.SrcA, 0);
        step();
        chk("bp3_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rel_srcb", bus.SrcB, 32'h55);
        chk("bp_rel_store", bus.store_data, 32'h55);
        chk("bp_rel_in_ready", bus.in_ready, 1);
        step();
        chk("bp_done_valid", bus.out_valid, 0);

        // flush together with in_fire drops the new instruction
        instr(1, 1, 2, 2, 0, 0, 4'h6, 2'b00, 1'b0, 5'd10);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 1);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_fire_valid", bus.out_valid, 0);

        // flush of a held instruction; pc select on SrcA
        bus.out_ready = 1'b0;
        instr(0, 0, 0, 0, 0, 32'h1000, 4'h7, 2'b01, 1'b1, 5'd11);
        step();
        bus.in_valid = 1'b0;
        chk("pc_srca", bus.SrcA, 32'h1000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_hold_valid", bus.out_valid, 0);

        // store-style hazard on rs2 with b_imm=1, then reset mid-stall
        exm_is_load = 1'b1; exm_we = 1'b1; exm_rd = 7;
        instr(0, 0, 7, 32'h44, 32'h8, 0, 4'h1, 2'b10, 1'b1, 5'd0);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("st_stall", bus.load_use_stall, 1);
        chk("st_valid", bus.out_valid, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", bus.load_use_stall, 0);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        exm_is_load = 1'b0; exm_we = 1'b0;
        step();
        step();
        chk("rst_after_valid", bus.out_valid, 0);
        chk("rst_after_rw", bus.ex_reg_write, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
